fp_mul_arbiter: RTL and testbench

//   Shares one multiplier32FP instance among NUM_REQ requesters.

---
 rtl/fp_mul_arbiter.sv | 153 +++++++++++++++
 tb/tb_fp_mul_arbiter.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/fp_mul_arbiter.sv
// Round-robin arbiter that shares one FP multiplier among NUM_REQ clients.
// Each granted operation is sequenced start -> done -> response, with a wait timeout.
module fp_mul_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int ID_W        = 2,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_REQ-1:0]      req_valid_i,
    output logic [NUM_REQ-1:0]      req_ready_o,
    input  logic [NUM_REQ*32-1:0]   req_a_i,
    input  logic [NUM_REQ*32-1:0]   req_b_i,
    output logic                    mul_start_o,
    output logic [31:0]             mul_a_o,
    output logic [31:0]             mul_b_o,
    input  logic                    mul_done_i,
    input  logic                    mul_nan_i,
    input  logic                    mul_inf_i,
    input  logic                    mul_ovf_i,
    input  logic                    mul_unf_i,
    input  logic [31:0]             mul_product_i,
    output logic                    resp_valid_o,
    input  logic                    resp_ready_i,
    output logic [ID_W-1:0]         resp_id_o,
    output logic [31:0]             resp_product_o,
    output logic [4:0]              resp_flags_o,
    output logic                    busy_o
);

    // state   | meaning
    // S_IDLE  | no operation; combinational one-hot grant offered
    // S_ISSUE | operands latched, start pulse high this cycle
    // S_WAIT  | waiting for done, wait counter running
    // S_RESP  | response held until resp_ready_i
    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    localparam int              CNT_W           = $clog2(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0] CNT_LAST       = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [ID_W:0]   NREQ            = (ID_W + 1)'(NUM_REQ);
    localparam logic [ID_W-1:0] ID_LAST         = ID_W'(NUM_REQ - 1);
    localparam logic [31:0]     TIMEOUT_PRODUCT = 32'h7FC0_0000;

    state_t            state_q;
    logic [ID_W-1:0]   rr_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              start_q;
    logic [31:0]       a_q;
    logic [31:0]       b_q;
    logic [ID_W-1:0]   id_q;
    logic [31:0]       prod_q;
    logic [4:0]        flags_q;
    logic              valid_q;
    logic              busy_q;

    logic [ID_W-1:0]   grant_id;
    logic              grant_hit;
    logic [ID_W:0]     scan_idx;
    logic [ID_W-1:0]   rr_d;

    // First valid requester at or after rr_q, wrapping modulo NUM_REQ.
    always_comb begin
        grant_id  = '0;
        grant_hit = 1'b0;
        scan_idx  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            scan_idx = {1'b0, rr_q} + (ID_W + 1)'(i);
            if (scan_idx >= NREQ) begin
                scan_idx = scan_idx - NREQ;
            end
            if (!grant_hit && req_valid_i[scan_idx[ID_W-1:0]]) begin
                grant_hit = 1'b1;
                grant_id  = scan_idx[ID_W-1:0];
            end
        end
    end

    assign rr_d = (grant_id == ID_LAST) ? '0 : grant_id + ID_W'(1);

    // Gated by rst so that every output reads zero while reset is held.
    assign req_ready_o = (state_q == S_IDLE && grant_hit && !rst) ?
                         (NUM_REQ'(1) << grant_id) : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            rr_q    <= '0;
            cnt_q   <= '0;
            start_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            id_q    <= '0;
            prod_q  <= '0;
            flags_q <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            start_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (grant_hit) begin
                        a_q     <= req_a_i[{grant_id, 5'd0} +: 32];
                        b_q     <= req_b_i[{grant_id, 5'd0} +: 32];
                        id_q    <= grant_id;
                        rr_q    <= rr_d;
                        start_q <= 1'b1;
                        busy_q  <= 1'b1;
                        state_q <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    cnt_q   <= '0;
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    cnt_q <= cnt_q + CNT_W'(1);
                    // done takes priority over an expiring counter in the same cycle
                    if (mul_done_i) begin
                        prod_q  <= mul_product_i;
                        flags_q <= {1'b0, mul_nan_i, mul_inf_i, mul_ovf_i, mul_unf_i};
                        valid_q <= 1'b1;
                        state_q <= S_RESP;
                    end else if (cnt_q == CNT_LAST) begin
                        prod_q  <= TIMEOUT_PRODUCT;
                        flags_q <= 5'b10000;
                        valid_q <= 1'b1;
                        state_q <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (resp_ready_i) begin
                        valid_q <= 1'b0;
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign mul_start_o    = start_q;
    assign mul_a_o        = a_q;
    assign mul_b_o        = b_q;
    assign resp_valid_o   = valid_q;
    assign resp_id_o      = id_q;
    assign resp_product_o = prod_q;
    assign resp_flags_o   = flags_q;
    assign busy_o         = busy_q;

endmodule

// File: tb/tb_fp_mul_arbiter.sv
// Bench for fp_mul_arbiter: the bench plays the multiplier and checks grants and
// responses against a round-robin / timeout reference model.
module tb_fp_mul_arbiter;

    localparam int NUM_REQ = 4;
    localparam int ID_W    = 2;
    localparam int TO_CYC  = 64;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [NUM_REQ-1:0]    req_valid_i;
    logic [NUM_REQ-1:0]    req_ready_o;
    logic [NUM_REQ*32-1:0] req_a_i;
    logic [NUM_REQ*32-1:0] req_b_i;
    logic                  mul_start_o;
    logic [31:0]           mul_a_o;
    logic [31:0]           mul_b_o;
    logic                  mul_done_i;
    logic                  mul_nan_i;
    logic                  mul_inf_i;
    logic                  mul_ovf_i;
    logic                  mul_unf_i;
    logic [31:0]           mul_product_i;
    logic                  resp_valid_o;
    logic                  resp_ready_i;
    logic [ID_W-1:0]       resp_id_o;
    logic [31:0]           resp_product_o;
    logic [4:0]            resp_flags_o;
    logic                  busy_o;

    fp_mul_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W), .TIMEOUT_CYC(TO_CYC)) dut (
        .clk(clk), .rst(rst),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_a_i(req_a_i), .req_b_i(req_b_i),
        .mul_start_o(mul_start_o), .mul_a_o(mul_a_o), .mul_b_o(mul_b_o),
        .mul_done_i(mul_done_i), .mul_nan_i(mul_nan_i), .mul_inf_i(mul_inf_i),
        .mul_ovf_i(mul_ovf_i), .mul_unf_i(mul_unf_i), .mul_product_i(mul_product_i),
        .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i),
        .resp_id_o(resp_id_o), .resp_product_o(resp_product_o),
        .resp_flags_o(resp_flags_o), .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_err    = 0;
    int          ptr_m    = 0;
    logic [31:0] opa [NUM_REQ];
    logic [31:0] opb [NUM_REQ];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_ops();
        for (int k = 0; k < NUM_REQ; k++) begin
            opa[k] = $urandom();
            opb[k] = $urandom();
            req_a_i[32*k +: 32] = opa[k];
            req_b_i[32*k +: 32] = opb[k];
        end
    endtask

    function automatic int model_grant(input logic [NUM_REQ-1:0] mask);
        for (int i = 0; i < NUM_REQ; i++) begin
            if (mask[(ptr_m + i) % NUM_REQ]) return (ptr_m + i) % NUM_REQ;
        end
        return -1;
    endfunction

    // One full operation from the IDLE cycle back to the next IDLE cycle.
    // lat = cycles from start pulse to done; timeout=1 means done never comes.
    task automatic run_op(input logic [NUM_REQ-1:0] mask, input int lat,
                          input logic [31:0] prod, input logic [3:0] fl,
                          input bit timeout, input int bp, output int got_id);
        int          id;
        int          s;
        bit          noisy;
        bit          unstable;
        logic [31:0] exp_p;
        logic [4:0]  exp_f;
        req_valid_i  = mask;
        resp_ready_i = (bp == 0);
        #1;
        id = model_grant(mask);
        chk("grant_onehot", req_ready_o, 64'(NUM_REQ'(1) << id));
        step();
        chk("start_pulse", mul_start_o, 1);
        chk("mul_a", mul_a_o, opa[id]);
        chk("mul_b", mul_b_o, opb[id]);
        chk("busy_issue", busy_o, 1);
        chk("ready_low_issue", req_ready_o, 0);
        ptr_m = (id + 1) % NUM_REQ;
        s = timeout ? TO_CYC : lat;
        noisy = 1'b0;
        for (int k = 0; k < s; k++) begin
            step();
            if (mul_start_o || resp_valid_o || req_ready_o != '0 || !busy_o) noisy = 1'b1;
        end
        chk("quiet_wait", noisy, 0);
        if (!timeout) begin
            mul_done_i    = 1'b1;
            mul_product_i = prod;
            {mul_nan_i, mul_inf_i, mul_ovf_i, mul_unf_i} = fl;
        end
        step();
        mul_done_i    = 1'b0;
        mul_product_i = $urandom();
        {mul_nan_i, mul_inf_i, mul_ovf_i, mul_unf_i} = 4'($urandom());
        exp_p = timeout ? 32'h7FC0_0000 : prod;
        exp_f = timeout ? 5'b10000 : {1'b0, fl};
        chk("resp_valid", resp_valid_o, 1);
        chk("resp_id", resp_id_o, id);
        chk("resp_product", resp_product_o, exp_p);
        chk("resp_flags", resp_flags_o, exp_f);
        got_id = int'(resp_id_o);
        if (bp > 0) begin
            unstable = 1'b0;
            for (int k = 0; k < bp; k++) begin
                step();
                if (resp_valid_o !== 1'b1 || resp_id_o !== ID_W'(id) || resp_product_o !== exp_p ||
                    resp_flags_o !== exp_f || req_ready_o !== '0 || mul_start_o !== 1'b0 ||
                    mul_a_o !== opa[id])
                    unstable = 1'b1;
            end
            chk("backpressure_hold", unstable, 0);
            resp_ready_i = 1'b1;
        end
        step();
        chk("resp_cleared", resp_valid_o, 0);
        chk("idle_not_busy", busy_o, 0);
        req_valid_i = '0;
    endtask

    initial begin
        int          got;
        int          rr_exp [5];
        logic [3:0]  m;
        rr_exp = '{0, 1, 2, 3, 0};
        rst = 1'b1;
        req_valid_i = '0;
        req_a_i = '0;
        req_b_i = '0;
        mul_done_i = 1'b0;
        {mul_nan_i, mul_inf_i, mul_ovf_i, mul_unf_i} = 4'b0;
        mul_product_i = '0;
        resp_ready_i = 1'b1;
        #2;
        chk("rst_outputs", {req_ready_o, mul_start_o, mul_a_o, mul_b_o, resp_valid_o,
                            resp_id_o, resp_product_o[7:0], resp_flags_o, busy_o}, 0);
        chk("rst_product", resp_product_o, 0);
        step();
        rst = 1'b0;
        load_ops();

        for (int i = 0; i < 5; i++) begin
            run_op(4'hF, $urandom_range(1, 8), $urandom(), 4'h0, 0, 0, got);
            chk("rr_order", got, rr_exp[i]);
        end

        opa[0] = 32'h4000_0000;
        opb[0] = 32'h4040_0000;
        req_a_i[31:0] = opa[0];
        req_b_i[31:0] = opb[0];
        run_op(4'b0001, 5, 32'h40C0_0000, 4'h0, 0, 0, got);

        load_ops();
        run_op(4'b0110, 3, 32'h1234_5678, 4'b0011, 0, 10, got);

        run_op(4'b1000, 0, 32'h0, 4'h0, 1, 0, got);
        mul_done_i = 1'b1;
        mul_product_i = 32'hDEAD_BEEF;
        step();
        mul_done_i = 1'b0;
        step();
        chk("late_done_ignored", {resp_valid_o, busy_o, mul_start_o}, 0);

        run_op(4'b0100, TO_CYC, 32'h3F80_0000, 4'b0100, 0, 0, got);

        opa[0] = 32'h7F80_0000;
        opb[0] = 32'h0000_0000;
        req_a_i[31:0] = opa[0];
        req_b_i[31:0] = opb[0];
        run_op(4'b0001, 4, 32'h7FC0_0000, 4'b1000, 0, 0, got);

        for (int i = 0; i < 20; i++) begin
            load_ops();
            m = 4'($urandom_range(1, 15));
            run_op(m, $urandom_range(1, TO_CYC), $urandom(), 4'($urandom()),
                   ($urandom_range(0, 7) == 0), $urandom_range(0, 3), got);
        end

        // Land the pointer away from zero, then reset in the middle of WAIT.
        run_op(4'b0010, 2, 32'h1, 4'h0, 0, 0, got);
        req_valid_i = 4'hF;
        step();
        step();
        step();
        chk("busy_before_rst", busy_o, 1);
        rst = 1'b1;
        #1;
        chk("rst_mid_wait", {req_ready_o, mul_start_o, mul_a_o, mul_b_o, resp_valid_o,
                             resp_id_o, resp_product_o[7:0], resp_flags_o, busy_o}, 0);
        ptr_m = 0;
        step();
        rst = 1'b0;
        req_valid_i = '0;
        mul_done_i = 1'b1;
        mul_product_i = 32'hCAFE_F00D;
        step();
        mul_done_i = 1'b0;
        step();
        chk("stale_done_dropped", {resp_valid_o, busy_o}, 0);
        load_ops();
        run_op(4'hF, 3, 32'h5555_AAAA, 4'h0, 0, 0, got);
        chk("rr_ptr_after_rst", got, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
